// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-step arithmetic/logic, iterative shifts, lowest-differing-bit scan
// and shift-add multiply behind valid/ready handshakes, with result and flags registered.
module alu_seq #(
  parameter int WIDTH      = 32,
  parameter int SHW        = $clog2(WIDTH) + 1,
  parameter int ENABLE_MUL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [4:0]       control_ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero_flag,
  output logic             sign_bit
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
  typedef enum logic [2:0] {K_SINGLE, K_SHL, K_SHR, K_SRA, K_DIFF, K_MUL} kind_t;

  localparam logic [WIDTH-1:0] LP_W  = WIDTH'(WIDTH);
  localparam logic [SHW-1:0]   LP_WS = SHW'(WIDTH);

  state_t             r_state, w_next_state;
  kind_t              r_kind, w_kind;
  logic [WIDTH-1:0]   r_a, r_b, r_acc;
  logic [SHW-1:0]     r_cnt;

  logic               w_accept, w_is_add, w_carry, w_start_exec, w_last;
  logic [WIDTH-1:0]   w_single, w_direct, w_step_acc, w_final;
  logic [WIDTH:0]     w_sum_full, w_neg_full;
  logic [SHW-1:0]     w_amt;

  assign in_ready   = (r_state == S_IDLE) && !rst;
  assign out_valid  = (r_state == S_DONE);
  assign w_accept   = in_valid && in_ready;
  assign w_sum_full = {1'b0, input1} + {1'b0, input2};
  assign w_neg_full = {1'b0, ~input2} + (WIDTH+1)'(1);
  assign w_amt      = (input2 >= LP_W) ? LP_WS : input2[SHW-1:0];

  // Opcode decode and the value produced when the op finishes without iterating.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_kind   = K_SINGLE;
    w_single = '0;
    w_is_add = 1'b0;
    w_carry  = 1'b0;
    unique case (control_ALUop)
      5'b11111, 5'b00001, 5'b00101, 5'b00110: begin
        w_single = w_sum_full[WIDTH-1:0];
        w_is_add = 1'b1;
        w_carry  = w_sum_full[WIDTH];
      end
      5'b10000, 5'b00010: begin
        w_single = w_neg_full[WIDTH-1:0];
        w_is_add = 1'b1;
        w_carry  = w_neg_full[WIDTH];
      end
      5'b00011:                 w_single = input1 & input2;
      5'b00100:                 w_single = input1 ^ input2;
      5'b01000, 5'b01001, 5'b00111: w_single = input1;
      5'b10001, 5'b10100:       w_kind = K_SHL;
      5'b10010, 5'b10101:       w_kind = K_SHR;
      5'b10011, 5'b10110:       w_kind = K_SRA;
      5'b01111:                 w_kind = K_DIFF;
      5'b11000:                 if (ENABLE_MUL != 0) w_kind = K_MUL;
      default: ;
    endcase

    w_start_exec = 1'b0;
    w_direct     = w_single;
    unique case (w_kind)
      K_SHL, K_SHR, K_SRA: begin
        w_start_exec = (w_amt != '0);
        w_direct     = input1;
      end
      K_DIFF: begin
        w_start_exec = (input1 != input2);
        w_direct     = LP_W;
      end
      K_MUL:   w_start_exec = 1'b1;
      default: ;
    endcase
  end

  // One iteration step; w_last flags the step whose output is the final result.
  always_comb begin
    w_step_acc = r_acc;
    w_last     = (r_cnt == SHW'(1));
    w_final    = w_step_acc;
    unique case (r_kind)
      K_SHL:  w_step_acc = r_acc << 1;
      K_SHR:  w_step_acc = r_acc >> 1;
      K_SRA:  w_step_acc = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
      K_MUL:  w_step_acc = r_acc + (r_b[0] ? r_a : '0);
      K_DIFF: w_step_acc = r_acc >> 1;
      default: ;
    endcase
    if (r_kind == K_DIFF) begin
      w_last  = r_acc[0];
      w_final = WIDTH'(r_cnt);
    end else begin
      w_final = w_step_acc;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next_state = w_start_exec ? S_EXEC : S_DONE;
      S_EXEC:  if (w_last) w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: only architecturally visible outputs are reset; operand/iteration registers
  // are always reloaded on accept before they are read, so they carry no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      carry     <= 1'b0;
      zero_flag <= 1'b0;
      sign_bit  <= 1'b0;
    end else if (w_accept) begin
      r_kind <= w_kind;
      r_a    <= input1;
      r_b    <= input2;
      unique case (w_kind)
        K_DIFF: begin r_acc <= input1 ^ input2; r_cnt <= '0;    end
        K_MUL:  begin r_acc <= '0;              r_cnt <= LP_WS; end
        default: begin r_acc <= input1;         r_cnt <= w_amt; end
      endcase
      if (w_is_add) carry <= w_carry;
      if (!w_start_exec) begin
        result    <= w_direct;
        zero_flag <= (w_direct == '0);
        sign_bit  <= w_direct[WIDTH-1];
      end
    end else if (r_state == S_EXEC) begin
      r_acc <= w_step_acc;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= (r_kind == K_DIFF) ? r_cnt + SHW'(1) : r_cnt - SHW'(1);
      if (w_last) begin
        result    <= w_final;
        zero_flag <= (w_final == '0);
        sign_bit  <= w_final[WIDTH-1];
      end
    end
  end

endmodule
